// File: rtl/fifo_rd_stream_pkg.sv
// Shared constants and the pop-credit helper for the FIFO read-side stream adapter.
// Optional error checking is built in when FIFO_RD_STREAM_ERR_EN is defined.
package fifo_rd_stream_pkg;

  localparam int FRS_DATA_W = 32;
  localparam int SKID_DEPTH = 2;

  typedef logic [1:0] occ_t;

  // True when next-cycle occupancy leaves room for one more word in flight.
  function automatic logic credit_ok(occ_t occ, logic in_fire, logic out_fire);
    logic [2:0] n;
    n = {1'b0, occ} + {2'b00, in_fire} - {2'b00, out_fire};
    return n < 3'(SKID_DEPTH);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_skid_buf2.sv
// Two-entry register skid buffer: ping-pong storage, 1-bit pointers, 2-bit occupancy.
// Head data is a plain mux of registers so the consumer sees no input-to-output path.
module fifo_rd_stream_skid_buf2
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_W = FRS_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_dat,
  input  logic              i_pop,
  output occ_t              o_occ,
  output logic [DATA_W-1:0] o_head_dat
);

  logic [DATA_W-1:0] r_buf [SKID_DEPTH];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  occ_t              r_occ;

  genvar gi;
  generate
    for (gi = 0; gi < SKID_DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_buf[gi] <= '0;
        end else if (i_push && (r_wr_ptr == 1'(gi))) begin
          r_buf[gi] <= i_push_dat;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= '0;
    end else begin
      if (i_push) r_wr_ptr <= ~r_wr_ptr;
      if (i_pop)  r_rd_ptr <= ~r_rd_ptr;
      r_occ <= r_occ + {1'b0, i_push} - {1'b0, i_pop};
    end
  end

  assign o_occ      = r_occ;
  assign o_head_dat = r_buf[r_rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter for a sync FIFO: issues pops against skid-buffer credit and streams words out.
// Define FIFO_RD_STREAM_ERR_EN to enable the sticky protocol-error flag (err).
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DATA_W = FRS_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              fifo_empty,
  output logic              fifo_pop,
  input  logic [DATA_W-1:0] fifo_pop_dat,
  input  logic              fifo_pop_dat_vld,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_dat,
  input  logic              out_rdy,
  output logic              err
);

  logic w_in_fire;
  logic w_out_fire;
  logic w_push;
  occ_t w_occ;

  assign w_in_fire  = fifo_pop_dat_vld;
  assign w_out_fire = out_vld & out_rdy;
  assign out_vld    = (w_occ != 2'd0);
  assign fifo_pop   = en & ~fifo_empty & credit_ok(w_occ, w_in_fire, w_out_fire);

`ifdef FIFO_RD_STREAM_ERR_EN
  logic r_pop_prev;
  logic r_err;
  logic w_overflow;
  logic w_spurious;

  // An overflowing word is dropped so the buffered words stay intact.
  assign w_overflow = w_in_fire & (w_occ == 2'd2) & ~w_out_fire;
  assign w_spurious = w_in_fire & ~r_pop_prev;
  assign w_push     = w_in_fire & ~w_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pop_prev <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_pop_prev <= fifo_pop;
      if (w_overflow || w_spurious) r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  assign w_push = w_in_fire;
  assign err    = 1'b0;
`endif

  fifo_rd_stream_skid_buf2 #(
    .DATA_W(DATA_W)
  ) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_dat (fifo_pop_dat),
    .i_pop      (w_out_fire),
    .o_occ      (w_occ),
    .o_head_dat (out_dat)
  );

endmodule
